seq_alu: RTL and testbench

Parametrised, registered ALU for the CPU datapath. It adds carry-chained add/subtract, an arithmetic shift, XOR, and multi-cycle unsigned multiply, divide and modulo. Operations are issued with a start/busy/done handshake. Single-cycle operations complete one cycle after acceptance; MUL/DIV/MOD run an iterative engine for WIDTH cycles. Results and the C/V/N/Z flags are held in registers until the next completed operation.

---
 rtl/seq_alu_if.sv | 32 +++
 rtl/seq_alu.sv | 245 ++++++++++++++++++++++++
 tb/tb_seq_alu.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// seq_alu_if: request/result bundle for the sequential ALU.
//   start/fs/a/b        : operation request, driven by the requester (master)
//   y/y_hi              : primary and secondary results
//   done/busy           : completion pulse and multi-cycle-in-progress status
//   c/v/n/z/err         : registered status flags
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [3:0]       fs;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_hi;
  logic             done;
  logic             busy;
  logic             c;
  logic             v;
  logic             n;
  logic             z;
  logic             err;

  modport master (
    output start, fs, a, b,
    input  y, y_hi, done, busy, c, v, n, z, err
  );

  modport slave (
    input  start, fs, a, b,
    output y, y_hi, done, busy, c, v, n, z, err
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with add/sub (carry-chained), shifts, logic ops and
// iterative unsigned multiply / divide / modulo.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_alu_if slave; start/fs/a/b are sampled when the request is
//           accepted, results and flags are held until the next completion.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;
  typedef enum logic [3:0] {
    F_ADD = 4'd0, F_SUB, F_ADC, F_SBC, F_SHL, F_SHR, F_ASR,
    F_AND, F_OR, F_XOR, F_MUL, F_DIV, F_MOD
  } fn_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;

  // Accepted request, executed on the following edge.
  logic             pend;
  logic [3:0]       op_fs;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_cin;

  // Shared iterative engine: hi = partial product high / remainder,
  // lo = multiplier / quotient, opnd = multiplicand / divisor.
  logic [WIDTH-1:0] hi, lo, opnd;
  logic             is_mod;

  logic [WIDTH-1:0] y_r, yhi_r;
  logic             c_r, v_r, n_r, z_r, err_r, done_r;

  logic             pend_multi, accept, last, load;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff, add_s;
  logic             div_ok;
  logic [WIDTH-1:0] step_hi, step_lo, beff;
  logic             ci;

  logic             wr, wr_c, wr_v, wr_err;
  logic [WIDTH-1:0] wr_y, wr_hi;

  // A pending multi-cycle op has not raised busy yet; hold off further
  // requests until the engine has taken it.
  assign pend_multi = pend && ((op_fs == F_MUL) ||
                      (((op_fs == F_DIV) || (op_fs == F_MOD)) && (op_b != '0)));
  assign accept     = bus.start && (state == IDLE) && !pend_multi;
  assign last       = (cnt == CW'(WIDTH - 1));

  // One engine step: shift-add multiply or restoring divide.
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    div_sh   = {hi, lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd};
    div_ok   = !div_diff[WIDTH];
    if (state == MUL_RUN) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo[WIDTH-1:1]};
    end else begin
      step_hi = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      step_lo = {lo[WIDTH-2:0], div_ok};
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    wr        = 1'b0;
    wr_y      = '0;
    wr_hi     = '0;
    wr_c      = 1'b0;
    wr_v      = 1'b0;
    wr_err    = 1'b0;
    beff      = ((op_fs == F_SUB) || (op_fs == F_SBC)) ? ~op_b : op_b;
    ci        = (op_fs == F_SUB) ? 1'b1 :
                ((op_fs == F_ADC) || (op_fs == F_SBC)) ? op_cin : 1'b0;
    add_s     = {1'b0, op_a} + {1'b0, beff} + {{WIDTH{1'b0}}, ci};
    case (state)
      IDLE: begin
        if (pend) begin
          case (op_fs)
            F_ADD, F_SUB, F_ADC, F_SBC: begin
              wr   = 1'b1;
              wr_y = add_s[WIDTH-1:0];
              wr_c = add_s[WIDTH];
              wr_v = (op_a[WIDTH-1] == beff[WIDTH-1]) &&
                     (add_s[WIDTH-1] != op_a[WIDTH-1]);
            end
            F_SHL: begin
              wr   = 1'b1;
              wr_y = {op_a[WIDTH-2:0], 1'b0};
              wr_c = op_a[WIDTH-1];
            end
            F_SHR: begin
              wr   = 1'b1;
              wr_y = {1'b0, op_a[WIDTH-1:1]};
              wr_c = op_a[0];
            end
            F_ASR: begin
              wr   = 1'b1;
              wr_y = {op_a[WIDTH-1], op_a[WIDTH-1:1]};
              wr_c = op_a[0];
            end
            F_AND: begin
              wr   = 1'b1;
              wr_y = op_a & op_b;
            end
            F_OR: begin
              wr   = 1'b1;
              wr_y = op_a | op_b;
            end
            F_XOR: begin
              wr   = 1'b1;
              wr_y = op_a ^ op_b;
            end
            F_MUL: begin
              load      = 1'b1;
              state_nxt = MUL_RUN;
              cnt_nxt   = '0;
            end
            F_DIV, F_MOD: begin
              if (op_b == '0) begin
                wr     = 1'b1;
                wr_y   = '1;
                wr_hi  = op_a;
                wr_err = 1'b1;
              end else begin
                load      = 1'b1;
                state_nxt = DIV_RUN;
                cnt_nxt   = '0;
              end
            end
            default: begin
              wr     = 1'b1;
              wr_err = 1'b1;
            end
          endcase
        end
      end
      MUL_RUN, DIV_RUN: begin
        cnt_nxt = cnt + CW'(1);
        // The final iteration is folded into the result write.
        if (last) begin
          wr        = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
          if (state == MUL_RUN) begin
            wr_y  = step_lo;
            wr_hi = step_hi;
            wr_c  = (step_hi != '0);
          end else begin
            wr_y  = is_mod ? step_hi : step_lo;
            wr_hi = is_mod ? step_lo : step_hi;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend   <= 1'b0;
      op_fs  <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_cin <= 1'b0;
    end else begin
      pend <= accept;
      if (accept) begin
        op_fs  <= bus.fs;
        op_a   <= bus.a;
        op_b   <= bus.b;
        op_cin <= c_r;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
      is_mod <= 1'b0;
    end else if (load) begin
      hi     <= '0;
      lo     <= op_a;
      opnd   <= op_b;
      is_mod <= (op_fs == F_MOD);
    end else if (state != IDLE) begin
      hi <= step_hi;
      lo <= step_lo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r    <= '0;
      yhi_r  <= '0;
      c_r    <= 1'b0;
      v_r    <= 1'b0;
      n_r    <= 1'b0;
      z_r    <= 1'b0;
      err_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= wr;
      if (wr) begin
        y_r   <= wr_y;
        yhi_r <= wr_hi;
        c_r   <= wr_c;
        v_r   <= wr_v;
        n_r   <= wr_y[WIDTH-1];
        z_r   <= (wr_y == '0);
        err_r <= wr_err;
      end
    end
  end

  assign bus.y    = y_r;
  assign bus.y_hi = yhi_r;
  assign bus.c    = c_r;
  assign bus.v    = v_r;
  assign bus.n    = n_r;
  assign bus.z    = z_r;
  assign bus.err  = err_r;
  assign bus.done = done_r;
  assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seq_alu_if #(.WIDTH(8)) bus ();
  seq_alu #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [3:0] fs;
    logic [7:0] a, b, y, hi;
    logic [4:0] fl;   // {c, v, n, z, err}
    int         lat;
    int         bsy;
  } vec_t;

  vec_t vt[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {bus.c, bus.v, bus.n, bus.z, bus.err};
  endfunction

  task automatic add_v(input string nm, input logic [3:0] f, input logic [7:0] a_, b_, y_, h_,
                       input logic [4:0] fl, input int lat, input int bsy);
    vec_t t;
    t = '{nm, f, a_, b_, y_, h_, fl, lat, bsy};
    vt.push_back(t);
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.busy) bcnt++;
    end
  endtask

  task automatic issue(input logic [3:0] f, input logic [7:0] ra, rb);
    @(negedge clk);
    bus.start = 1'b1;
    bus.fs = f;
    bus.a = ra;
    bus.b = rb;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = ~ra;   // operands must already be latched
    bus.b = ~rb;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat, bcnt;
    bus.start = 1'b0;
    bus.fs = '0;
    bus.a = '0;
    bus.b = '0;

    add_v("add_ovf",   4'd0,  8'h7F, 8'h01, 8'h80, 8'h00, 5'b01100, 1, 0);
    add_v("sub_eq",    4'd1,  8'h05, 8'h05, 8'h00, 8'h00, 5'b10010, 1, 0);
    add_v("asr_neg",   4'd6,  8'h81, 8'h00, 8'hC0, 8'h00, 5'b10100, 1, 0);
    add_v("add_carry", 4'd0,  8'hFF, 8'h01, 8'h00, 8'h00, 5'b10010, 1, 0);
    add_v("adc_cin1",  4'd2,  8'h00, 8'h00, 8'h01, 8'h00, 5'b00000, 1, 0);
    add_v("sbc_cin0",  4'd3,  8'h10, 8'h01, 8'h0E, 8'h00, 5'b10000, 1, 0);
    add_v("sbc_cin1",  4'd3,  8'h00, 8'h00, 8'h00, 8'h00, 5'b10010, 1, 0);
    add_v("sub_ovf",   4'd1,  8'h80, 8'h01, 8'h7F, 8'h00, 5'b11000, 1, 0);
    add_v("add_negov", 4'd0,  8'h80, 8'h80, 8'h00, 8'h00, 5'b11010, 1, 0);
    add_v("shl_out1",  4'd4,  8'h81, 8'h00, 8'h02, 8'h00, 5'b10000, 1, 0);
    add_v("shr_out1",  4'd5,  8'h81, 8'h00, 8'h40, 8'h00, 5'b10000, 1, 0);
    add_v("shl_out0",  4'd4,  8'h40, 8'h00, 8'h80, 8'h00, 5'b00100, 1, 0);
    add_v("asr_pos",   4'd6,  8'h7E, 8'h00, 8'h3F, 8'h00, 5'b00000, 1, 0);
    add_v("shr_zero",  4'd5,  8'h01, 8'h00, 8'h00, 8'h00, 5'b10010, 1, 0);
    add_v("and",       4'd7,  8'hF0, 8'h3C, 8'h30, 8'h00, 5'b00000, 1, 0);
    add_v("or",        4'd8,  8'hF0, 8'h0F, 8'hFF, 8'h00, 5'b00100, 1, 0);
    add_v("xor_zero",  4'd9,  8'hAA, 8'hAA, 8'h00, 8'h00, 5'b00010, 1, 0);
    add_v("xor",       4'd9,  8'hA5, 8'h0F, 8'hAA, 8'h00, 5'b00100, 1, 0);
    add_v("mul_max",   4'd10, 8'hFF, 8'hFF, 8'h01, 8'hFE, 5'b10000, 9, 8);
    add_v("mul_256",   4'd10, 8'h10, 8'h10, 8'h00, 8'h01, 5'b10010, 9, 8);
    add_v("mul_small", 4'd10, 8'h0C, 8'h0B, 8'h84, 8'h00, 5'b00100, 9, 8);
    add_v("mul_zero",  4'd10, 8'h00, 8'h55, 8'h00, 8'h00, 5'b00010, 9, 8);
    add_v("div",       4'd11, 8'hC8, 8'h07, 8'h1C, 8'h04, 5'b00000, 9, 8);
    add_v("mod",       4'd12, 8'hC8, 8'h07, 8'h04, 8'h1C, 5'b00000, 9, 8);
    add_v("div_small", 4'd11, 8'h07, 8'hC8, 8'h00, 8'h07, 5'b00010, 9, 8);
    add_v("div_by1",   4'd11, 8'hFF, 8'h01, 8'hFF, 8'h00, 5'b00100, 9, 8);
    add_v("div_by0",   4'd11, 8'h33, 8'h00, 8'hFF, 8'h33, 5'b00101, 1, 0);
    add_v("mod_by0",   4'd12, 8'h33, 8'h00, 8'hFF, 8'h33, 5'b00101, 1, 0);
    add_v("rsv13",     4'd13, 8'h12, 8'h34, 8'h00, 8'h00, 5'b00011, 1, 0);
    add_v("rsv14",     4'd14, 8'h12, 8'h34, 8'h00, 8'h00, 5'b00011, 1, 0);
    add_v("rsv15",     4'd15, 8'hFF, 8'hFF, 8'h00, 8'h00, 5'b00011, 1, 0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_y",    {8'h0, bus.y}, 16'h0);
    chk("rst_y_hi", {8'h0, bus.y_hi}, 16'h0);
    chk("rst_flags", {11'h0, flags()}, 16'h0);
    chk("rst_done_busy", {14'h0, bus.done, bus.busy}, 16'h0);
    rst_n = 1'b1;

    // Table-driven vectors
    foreach (vt[i]) begin
      issue(vt[i].fs, vt[i].a, vt[i].b);
      wait_done(lat, bcnt);
      chk({vt[i].nm, "_y"},     {8'h0, bus.y}, {8'h0, vt[i].y});
      chk({vt[i].nm, "_y_hi"},  {8'h0, bus.y_hi}, {8'h0, vt[i].hi});
      chk({vt[i].nm, "_flags"}, {11'h0, flags()}, {11'h0, vt[i].fl});
      chk({vt[i].nm, "_lat"},   16'(lat), 16'(vt[i].lat));
      chk({vt[i].nm, "_busy"},  16'(bcnt), 16'(vt[i].bsy));
      chk({vt[i].nm, "_busy_at_done"}, {15'h0, bus.busy}, 16'h0);
      @(negedge clk);
      chk({vt[i].nm, "_done_pulse"}, {15'h0, bus.done}, 16'h0);
    end

    // ADC issued in the done cycle of ADD sees the new carry
    issue(4'd0, 8'hFF, 8'h01);
    wait_done(lat, bcnt);
    chk("chain_add_c", {15'h0, bus.c}, 16'h1);
    bus.start = 1'b1;
    bus.fs = 4'd2;
    bus.a = 8'h00;
    bus.b = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, bcnt);
    chk("chain_adc_y", {8'h0, bus.y}, 16'h0001);
    chk("chain_adc_c", {15'h0, bus.c}, 16'h0);
    chk("chain_adc_lat", 16'(lat), 16'd1);

    // Back-to-back single-cycle ops
    @(negedge clk);
    bus.start = 1'b1;
    bus.fs = 4'd0;
    bus.a = 8'h01;
    bus.b = 8'h02;
    @(negedge clk);
    bus.fs = 4'd9;
    bus.a = 8'hF0;
    bus.b = 8'h0F;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_first_y", {7'h0, bus.done, bus.y}, 16'h0103);
    @(negedge clk);
    chk("b2b_second_y", {7'h0, bus.done, bus.y}, 16'h01FF);
    chk("b2b_second_n", {15'h0, bus.n}, 16'h1);

    // MUL with a start pulse during busy: ignored
    issue(4'd10, 8'hFF, 8'hFF);
    repeat (3) @(negedge clk);
    chk("mul_ign_busy", {15'h0, bus.busy}, 16'h1);
    chk("mul_hold_y", {8'h0, bus.y}, 16'h00FF);
    bus.start = 1'b1;
    bus.fs = 4'd0;
    bus.a = 8'h01;
    bus.b = 8'h01;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, bcnt);
    chk("mul_ign_lat", 16'(lat + 4), 16'd9);
    chk("mul_ign_y", {bus.y_hi, bus.y}, 16'hFE01);
    chk("mul_ign_c", {15'h0, bus.c}, 16'h1);
    bcnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done || bus.busy) bcnt++;
    end
    chk("mul_ign_no_extra", 16'(bcnt), 16'd0);
    chk("mul_ign_y_hold", {bus.y_hi, bus.y}, 16'hFE01);

    // Reset in the middle of a MUL
    issue(4'd10, 8'hFF, 8'hFF);
    bcnt = 0;
    lat = 0;
    while (bcnt < 4 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.busy) bcnt++;
    end
    chk("mid_rst_reached", 16'(bcnt), 16'd4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_y", {bus.y_hi, bus.y}, 16'h0);
    chk("mid_rst_flags", {11'h0, flags()}, 16'h0);
    chk("mid_rst_done_busy", {14'h0, bus.done, bus.busy}, 16'h0);
    bcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) bcnt++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.done || bus.busy) bcnt++;
    end
    chk("mid_rst_no_done", 16'(bcnt), 16'd0);
    issue(4'd0, 8'h02, 8'h03);
    wait_done(lat, bcnt);
    chk("post_rst_y", {8'h0, bus.y}, 16'h0005);
    chk("post_rst_err", {15'h0, bus.err}, 16'h0);
    chk("post_rst_lat", 16'(lat), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
